// File: rtl/alu_exec_unit_pkg.sv
// alu_exec_unit_pkg: shared opcode IDs, bus widths and boolean constants for the ALU execution unit
package alu_exec_unit_pkg;
    localparam int DataWidth = 32;
    localparam int OpIdBus = 6;
    localparam int ROBIDBus = 4;
    localparam logic True = 1'b1;
    localparam logic False = 1'b0;
    typedef logic [OpIdBus-1:0] op_id_t;
    localparam op_id_t OP_LUI    = 6'd0;
    localparam op_id_t OP_AUIPC  = 6'd1;
    localparam op_id_t OP_JAL    = 6'd2;
    localparam op_id_t OP_JALR   = 6'd3;
    localparam op_id_t OP_BEQ    = 6'd4;
    localparam op_id_t OP_BNE    = 6'd5;
    localparam op_id_t OP_BLT    = 6'd6;
    localparam op_id_t OP_BGE    = 6'd7;
    localparam op_id_t OP_BLTU   = 6'd8;
    localparam op_id_t OP_BGEU   = 6'd9;
    localparam op_id_t OP_ADDI   = 6'd10;
    localparam op_id_t OP_SLTI   = 6'd11;
    localparam op_id_t OP_SLTIU  = 6'd12;
    localparam op_id_t OP_XORI   = 6'd13;
    localparam op_id_t OP_ORI    = 6'd14;
    localparam op_id_t OP_ANDI   = 6'd15;
    localparam op_id_t OP_SLLI   = 6'd16;
    localparam op_id_t OP_SRLI   = 6'd17;
    localparam op_id_t OP_SRAI   = 6'd18;
    localparam op_id_t OP_ADD    = 6'd19;
    localparam op_id_t OP_SUB    = 6'd20;
    localparam op_id_t OP_SLL    = 6'd21;
    localparam op_id_t OP_SLT    = 6'd22;
    localparam op_id_t OP_SLTU   = 6'd23;
    localparam op_id_t OP_XOR    = 6'd24;
    localparam op_id_t OP_SRL    = 6'd25;
    localparam op_id_t OP_SRA    = 6'd26;
    localparam op_id_t OP_OR     = 6'd27;
    localparam op_id_t OP_AND    = 6'd28;
    localparam op_id_t OP_MUL    = 6'd29;
    localparam op_id_t OP_MULH   = 6'd30;
    localparam op_id_t OP_MULHSU = 6'd31;
    localparam op_id_t OP_MULHU  = 6'd32;
endpackage

// File: rtl/alu_exec_unit_result_fifo.sv
// alu_result_fifo: in-order result buffer with flush; a full FIFO accepts a push when it pops in the same cycle
module alu_result_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    assign do_pop = pop & (count != '0);
    assign do_push = push & ((count != (AW+1)'(DEPTH)) | do_pop);
    assign dout = mem[rd_ptr];
    // pointer and occupancy bookkeeping; flush and reset both empty the buffer
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else if (en) begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count <= '0;
            end else begin
                wr_ptr <= do_push ? wr_ptr + 1'b1 : wr_ptr;
                rd_ptr <= do_pop ? rd_ptr + 1'b1 : rd_ptr;
                count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
            end
        end
    end
    // entry storage, written only on an accepted push
    always_ff @(posedge clk) begin
        if (!rst && en && !flush && do_push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: single-cycle RV32I ALU/branch/jump unit with result FIFO; ALU_EXEC_MUL_EN adds MUL/MULH/MULHSU/MULHU
module alu_exec_unit
    import alu_exec_unit_pkg::*;
#(
    parameter int DATA_W = DataWidth,
    parameter int ROB_ID_W = ROBIDBus,
    parameter int OP_W = OpIdBus,
    parameter int RES_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic                flush,
    input  logic                RS_input_valid,
    output logic                RS_ready,
    input  logic [OP_W-1:0]     RS_OP_ID,
    input  logic [DATA_W-1:0]   RS_pc,
    input  logic [DATA_W-1:0]   RS_reg_rs1,
    input  logic [DATA_W-1:0]   RS_reg_rs2,
    input  logic [DATA_W-1:0]   RS_imm,
    input  logic [ROB_ID_W-1:0] RS_ROB_id,
    output logic                ROB_enable,
    input  logic                ROB_ready,
    output logic [ROB_ID_W-1:0] ROB_ROB_id,
    output logic [DATA_W-1:0]   ROB_value,
    output logic                ROB_jump,
    output logic [DATA_W-1:0]   ROB_target
);
    localparam int SH_W = $clog2(DATA_W);
    localparam int CW = $clog2(RES_DEPTH) + 1;
    typedef struct packed {
        logic [DATA_W-1:0] value;
        logic              jump;
        logic [DATA_W-1:0] target;
    } res_t;
    typedef struct packed {
        logic [ROB_ID_W-1:0] id;
        logic [DATA_W-1:0]   value;
        logic                jump;
        logic [DATA_W-1:0]   target;
    } entry_t;

    function automatic res_t compute(
        input logic [OP_W-1:0]   op,
        input logic [DATA_W-1:0] pc,
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b,
        input logic [DATA_W-1:0] imm
    );
        res_t r;
        logic [SH_W-1:0] shr, shi;
`ifdef ALU_EXEC_MUL_EN
        logic [2*DATA_W-1:0] p_ss, p_su, p_uu;
        p_ss = {{DATA_W{a[DATA_W-1]}}, a} * {{DATA_W{b[DATA_W-1]}}, b};
        p_su = {{DATA_W{a[DATA_W-1]}}, a} * {{DATA_W{1'b0}}, b};
        p_uu = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
`endif
        shr = b[SH_W-1:0];
        shi = imm[SH_W-1:0];
        r.value = '0;
        r.jump = False;
        r.target = pc + DATA_W'(4);
        case (op)
            OP_LUI:    r.value = imm;
            OP_AUIPC:  r.value = pc + imm;
            OP_JAL:    begin r.value = pc + DATA_W'(4); r.jump = True; end
            OP_JALR:   begin r.value = pc + DATA_W'(4); r.jump = True; end
            OP_BEQ:    r.jump = a == b;
            OP_BNE:    r.jump = a != b;
            OP_BLT:    r.jump = $signed(a) < $signed(b);
            OP_BGE:    r.jump = $signed(a) >= $signed(b);
            OP_BLTU:   r.jump = a < b;
            OP_BGEU:   r.jump = a >= b;
            OP_ADDI:   r.value = a + imm;
            OP_SLTI:   r.value = DATA_W'($signed(a) < $signed(imm));
            OP_SLTIU:  r.value = DATA_W'(a < imm);
            OP_XORI:   r.value = a ^ imm;
            OP_ORI:    r.value = a | imm;
            OP_ANDI:   r.value = a & imm;
            OP_SLLI:   r.value = a << shi;
            OP_SRLI:   r.value = a >> shi;
            OP_SRAI:   r.value = $unsigned($signed(a) >>> shi);
            OP_ADD:    r.value = a + b;
            OP_SUB:    r.value = a - b;
            OP_SLL:    r.value = a << shr;
            OP_SLT:    r.value = DATA_W'($signed(a) < $signed(b));
            OP_SLTU:   r.value = DATA_W'(a < b);
            OP_XOR:    r.value = a ^ b;
            OP_SRL:    r.value = a >> shr;
            OP_SRA:    r.value = $unsigned($signed(a) >>> shr);
            OP_OR:     r.value = a | b;
            OP_AND:    r.value = a & b;
`ifdef ALU_EXEC_MUL_EN
            OP_MUL:    r.value = p_uu[DATA_W-1:0];
            OP_MULH:   r.value = p_ss[2*DATA_W-1:DATA_W];
            OP_MULHSU: r.value = p_su[2*DATA_W-1:DATA_W];
            OP_MULHU:  r.value = p_uu[2*DATA_W-1:DATA_W];
`endif
            default:   r.value = '0;
        endcase
        if (r.jump) r.target = (op == OP_JALR) ? ((a + imm) & ~DATA_W'(1)) : pc + imm;
        return r;
    endfunction

    res_t res;
    entry_t head;
    logic [CW-1:0] count;
    logic issue, retire;

    // single-cycle datapath on the issued operands
    always_comb res = compute(RS_OP_ID, RS_pc, RS_reg_rs1, RS_reg_rs2, RS_imm);

    assign ROB_enable = count != '0;
    assign retire = ROB_enable & ROB_ready & rdy;
    assign RS_ready = rdy & ((count < CW'(RES_DEPTH)) | retire);
    assign issue = RS_input_valid & RS_ready & !flush;
    assign ROB_ROB_id = ROB_enable ? head.id : '0;
    assign ROB_value = ROB_enable ? head.value : '0;
    assign ROB_jump = ROB_enable & head.jump;
    assign ROB_target = ROB_enable ? head.target : '0;

    alu_result_fifo #(
        .WIDTH($bits(entry_t)),
        .DEPTH(RES_DEPTH)
    ) u_fifo (
        .clk(clk),
        .rst(rst),
        .en(rdy),
        .flush(flush),
        .push(issue),
        .pop(retire),
        .din({RS_ROB_id, res.value, res.jump, res.target}),
        .dout(head),
        .count(count)
    );
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed vectors with hand-computed results for alu_exec_unit
module tb_alu_exec_unit;
    import alu_exec_unit_pkg::*;
    logic clk = 1'b0;
    logic rst, rdy, flush, RS_input_valid, RS_ready, ROB_enable, ROB_ready, ROB_jump;
    logic [5:0] RS_OP_ID;
    logic [31:0] RS_pc, RS_reg_rs1, RS_reg_rs2, RS_imm, ROB_value, ROB_target;
    logic [3:0] RS_ROB_id, ROB_ROB_id;
    int checks = 0;
    int failures = 0;

    alu_exec_unit dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .RS_input_valid(RS_input_valid), .RS_ready(RS_ready), .RS_OP_ID(RS_OP_ID),
        .RS_pc(RS_pc), .RS_reg_rs1(RS_reg_rs1), .RS_reg_rs2(RS_reg_rs2), .RS_imm(RS_imm),
        .RS_ROB_id(RS_ROB_id), .ROB_enable(ROB_enable), .ROB_ready(ROB_ready),
        .ROB_ROB_id(ROB_ROB_id), .ROB_value(ROB_value), .ROB_jump(ROB_jump), .ROB_target(ROB_target)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [5:0] op, input logic [31:0] pc, a, b, imm, input logic [3:0] id);
        RS_OP_ID = op; RS_pc = pc; RS_reg_rs1 = a; RS_reg_rs2 = b; RS_imm = imm; RS_ROB_id = id;
        RS_input_valid = 1'b1;
    endtask

    task automatic exec(input string tag, input logic [5:0] op, input logic [31:0] pc, a, b, imm,
                        input logic [3:0] id, input logic [31:0] ev, input logic ej, input logic [31:0] et);
        drive(op, pc, a, b, imm, id);
        tick;
        RS_input_valid = 1'b0;
        check({tag, "_en"}, 64'(ROB_enable), 64'd1);
        check({tag, "_id"}, 64'(ROB_ROB_id), 64'(id));
        check({tag, "_val"}, 64'(ROB_value), 64'(ev));
        check({tag, "_jmp"}, 64'(ROB_jump), 64'(ej));
        check({tag, "_tgt"}, 64'(ROB_target), 64'(et));
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; flush = 1'b0; ROB_ready = 1'b0;
        drive(6'd0, 0, 0, 0, 0, 0);
        RS_input_valid = 1'b0;
        tick; tick;
        rst = 1'b0;
        #1;
        check("rst_en", 64'(ROB_enable), 0);
        check("rst_id", 64'(ROB_ROB_id), 0);
        check("rst_val", 64'(ROB_value), 0);
        check("rst_jmp", 64'(ROB_jump), 0);
        check("rst_tgt", 64'(ROB_target), 0);
        check("rst_rsrdy", 64'(RS_ready), 1);

        ROB_ready = 1'b1;
        exec("addi",  OP_ADDI,  32'h0,    32'd5,        32'd0,  32'hFFFFFFFD, 4'd2, 32'd2,        1'b0, 32'h4);
        exec("blt",   OP_BLT,   32'h100,  32'hFFFFFFFF, 32'd1,  32'h20,       4'd3, 32'd0,        1'b1, 32'h120);
        exec("bltu",  OP_BLTU,  32'h100,  32'hFFFFFFFF, 32'd1,  32'h20,       4'd4, 32'd0,        1'b0, 32'h104);
        exec("jalr",  OP_JALR,  32'h40,   32'h1001,     32'd0,  32'd4,        4'd5, 32'h44,       1'b1, 32'h1004);
        exec("srai",  OP_SRAI,  32'h0,    32'h80000000, 32'd0,  32'h21,       4'd6, 32'hC0000000, 1'b0, 32'h4);
        exec("lui",   OP_LUI,   32'h8,    32'd0,        32'd0,  32'h12345000, 4'd7, 32'h12345000, 1'b0, 32'hC);
        exec("auipc", OP_AUIPC, 32'h1000, 32'd0,        32'd0,  32'h2000,     4'd8, 32'h3000,     1'b0, 32'h1004);
        exec("jal",   OP_JAL,   32'h200,  32'd0,        32'd0,  32'hFFFFFFF0, 4'd9, 32'h204,      1'b1, 32'h1F0);
        exec("sub",   OP_SUB,   32'h0,    32'd3,        32'd5,  32'd0,        4'd1, 32'hFFFFFFFE, 1'b0, 32'h4);
        exec("slt",   OP_SLT,   32'h0,    32'hFFFFFFFF, 32'd1,  32'd0,        4'd2, 32'd1,        1'b0, 32'h4);
        exec("sltu",  OP_SLTU,  32'h0,    32'hFFFFFFFF, 32'd1,  32'd0,        4'd3, 32'd0,        1'b0, 32'h4);
        exec("sltiu", OP_SLTIU, 32'h0,    32'd5,        32'd0,  32'hFFFFFFFF, 4'd4, 32'd1,        1'b0, 32'h4);
        exec("sll",   OP_SLL,   32'h0,    32'd1,        32'h23, 32'd0,        4'd5, 32'd8,        1'b0, 32'h4);
        exec("srl",   OP_SRL,   32'h0,    32'h80000000, 32'd4,  32'd0,        4'd6, 32'h08000000, 1'b0, 32'h4);
        exec("bne",   OP_BNE,   32'h10,   32'd1,        32'd1,  32'd8,        4'd7, 32'd0,        1'b0, 32'h14);
        exec("bgeu",  OP_BGEU,  32'h10,   32'hFFFFFFFF, 32'd1,  32'd8,        4'd8, 32'd0,        1'b1, 32'h18);
        exec("xori",  OP_XORI,  32'h0,    32'hF0,       32'd0,  32'hFF,       4'd9, 32'h0F,       1'b0, 32'h4);
        exec("unk",   6'h3F,    32'h20,   32'd7,        32'd9,  32'd3,        4'd1, 32'd0,        1'b0, 32'h24);
`ifdef ALU_EXEC_MUL_EN
        exec("mulhu", OP_MULHU, 32'h0, 32'hFFFFFFFF, 32'd2, 32'd0, 4'd2, 32'd1,        1'b0, 32'h4);
        exec("mulh",  OP_MULH,  32'h0, 32'hFFFFFFFF, 32'd2, 32'd0, 4'd3, 32'hFFFFFFFF, 1'b0, 32'h4);
        exec("mul",   OP_MUL,   32'h0, 32'hFFFFFFFF, 32'd2, 32'd0, 4'd4, 32'hFFFFFFFE, 1'b0, 32'h4);
`else
        exec("mulhu", OP_MULHU, 32'h0, 32'hFFFFFFFF, 32'd2, 32'd0, 4'd2, 32'd0, 1'b0, 32'h4);
        exec("mulh",  OP_MULH,  32'h0, 32'hFFFFFFFF, 32'd2, 32'd0, 4'd3, 32'd0, 1'b0, 32'h4);
        exec("mul",   OP_MUL,   32'h0, 32'hFFFFFFFF, 32'd2, 32'd0, 4'd4, 32'd0, 1'b0, 32'h4);
`endif
        tick;
        check("drain_en", 64'(ROB_enable), 0);

        ROB_ready = 1'b0;
        drive(OP_ADDI, 0, 32'd1, 0, 0, 4'd1); tick;
        drive(OP_ADDI, 0, 32'd2, 0, 0, 4'd2); tick;
        drive(OP_ADDI, 0, 32'd3, 0, 0, 4'd3);
        #1;
        check("full_rsrdy", 64'(RS_ready), 0);
        tick;
        check("full_hold_id", 64'(ROB_ROB_id), 1);
        check("full_hold_rsrdy", 64'(RS_ready), 0);
        ROB_ready = 1'b1;
        #1;
        check("full_popready", 64'(RS_ready), 1);
        tick;
        RS_input_valid = 1'b0;
        check("ord1_id", 64'(ROB_ROB_id), 2);
        check("ord1_val", 64'(ROB_value), 2);
        tick;
        check("ord2_id", 64'(ROB_ROB_id), 3);
        check("ord2_val", 64'(ROB_value), 3);
        tick;
        check("ord_empty", 64'(ROB_enable), 0);

        ROB_ready = 1'b0;
        drive(OP_ADDI, 0, 32'd4, 0, 0, 4'd4); tick;
        drive(OP_ADDI, 0, 32'd5, 0, 0, 4'd5); tick;
        drive(OP_ADDI, 0, 32'd6, 0, 0, 4'd6);
        ROB_ready = 1'b1;
        flush = 1'b1;
        tick;
        flush = 1'b0; RS_input_valid = 1'b0; ROB_ready = 1'b0;
        check("flush_en", 64'(ROB_enable), 0);
        check("flush_val", 64'(ROB_value), 0);
        check("flush_rsrdy", 64'(RS_ready), 1);
        tick; tick;
        check("flush_stay_empty", 64'(ROB_enable), 0);
        ROB_ready = 1'b1;
        exec("post_flush", OP_ADD, 32'h0, 32'd7, 32'd1, 32'd0, 4'd7, 32'd8, 1'b0, 32'h4);
        tick;
        check("post_flush_drain", 64'(ROB_enable), 0);

        ROB_ready = 1'b0;
        drive(OP_ADDI, 0, 32'd8, 0, 0, 4'd8); tick;
        RS_input_valid = 1'b0;
        rdy = 1'b0; ROB_ready = 1'b1;
        drive(OP_ADDI, 0, 32'd10, 0, 0, 4'd10);
        #1;
        check("rdy0_rsrdy", 64'(RS_ready), 0);
        for (int i = 0; i < 3; i++) begin
            tick;
            check("rdy0_en", 64'(ROB_enable), 1);
            check("rdy0_id", 64'(ROB_ROB_id), 8);
            check("rdy0_val", 64'(ROB_value), 8);
        end
        rdy = 1'b1; RS_input_valid = 1'b0;
        #1;
        check("rdy1_rsrdy", 64'(RS_ready), 1);
        tick;
        check("rdy1_retired", 64'(ROB_enable), 0);

        ROB_ready = 1'b0;
        drive(OP_ADDI, 0, 32'd11, 0, 0, 4'd11); tick;
        RS_input_valid = 1'b0;
        check("mid_en", 64'(ROB_enable), 1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        #1;
        check("midrst_en", 64'(ROB_enable), 0);
        check("midrst_id", 64'(ROB_ROB_id), 0);
        check("midrst_rsrdy", 64'(RS_ready), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
